// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // FETCH: requesting words; FULL: queue holds DEPTH entries; FAULT: misaligned target
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      FULL  = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   // One prefetched instruction together with the address it came from
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, instruction memory, EX redirect and decode.
//
// Handshakes:
//  - imem: the sequencer presents imem_addr with imem_en; the word is taken only
//    in a cycle where imem_en && imem_ready are both high. With imem_ready low the
//    address and enable are held unchanged.
//  - decode: an instruction moves from fetch to decode exactly in a cycle where
//    instr_valid && instr_ready are both high. instr/instr_pc are stable while
//    instr_valid is high and instr_ready low, except when a redirect flushes them.
interface if_fetch_ctrl_if;
   import if_pkg::*;

   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] imem_addr;
   logic            imem_en;
   logic [XLEN-1:0] imem_data;
   logic            imem_ready;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic            misalign_fault;
   fetch_state_t    state;           // debug view of the sequencer FSM

   modport master (
      input  redirect, redirect_pc, imem_data, imem_ready, instr_ready,
      output imem_addr, imem_en, instr, instr_pc, instr_valid, misalign_fault, state
   );

   modport slave (
      output redirect, redirect_pc, imem_data, imem_ready, instr_ready,
      input  imem_addr, imem_en, instr, instr_pc, instr_valid, misalign_fault, state
   );

endinterface

// File: rtl/if_fetch_ctrl_queue.sv
// Prefetch FIFO of {pc, instr} entries with a combinational head and a flush.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t    mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;

   // Pointers and occupancy; flush empties the queue in one cycle
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage write; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // The controller only pushes while not full and only pops while not empty
   always_ff @(posedge clk) begin
      if (!reset && !flush) begin
         assert (!(push && !pop && full));
         assert (!(pop && empty));
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns fetch_pc, requests words from instruction
// memory, buffers them in a prefetch queue and hands them to decode.
module if_fetch_ctrl
   import if_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   if_fetch_ctrl_if.master bus
);

   localparam int CW = $clog2(DEPTH+1);

   fetch_state_t     state;
   fetch_state_t     state_next;
   logic [XLEN-1:0]  fetch_pc;
   logic             fault_q;
   logic             imem_en;
   logic             push;
   logic             pop;
   logic             instr_valid;
   logic             misaligned;
   fetch_entry_t     push_data;
   fetch_entry_t     head;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;

   if_fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.redirect),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   // Handshake qualifiers and next state; a redirect overrides push and occupancy
   always_comb begin
      imem_en     = (state == FETCH) && !reset;
      push        = imem_en && bus.imem_ready && !bus.redirect;
      instr_valid = !empty && (state != FAULT);
      pop         = instr_valid && bus.instr_ready;
      misaligned  = |bus.redirect_pc[1:0];
      push_data   = '{pc: fetch_pc, instr: bus.imem_data};
      state_next  = state;
      if (bus.redirect) begin
         state_next = misaligned ? FAULT : FETCH;
      end else if (state != FAULT) begin
         if ((full && !pop) || (push && !pop && count == CW'(DEPTH-1)))
            state_next = FULL;
         else
            state_next = FETCH;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   // Fetch PC: re-steered by redirect, advanced by one word per accepted request
   always_ff @(posedge clk) begin
      if (reset)             fetch_pc <= RESET_PC;
      else if (bus.redirect) fetch_pc <= bus.redirect_pc;
      else if (push)         fetch_pc <= fetch_pc + 32'd4;
   end

   // Misalignment flag follows the most recent redirect target
   always_ff @(posedge clk) begin
      if (reset)             fault_q <= 1'b0;
      else if (bus.redirect) fault_q <= misaligned;
   end

   assign bus.imem_addr      = fetch_pc;
   assign bus.imem_en        = imem_en;
   assign bus.instr_valid    = instr_valid;
   assign bus.instr          = instr_valid ? head.instr : NOP_INSTR;
   assign bus.instr_pc       = instr_valid ? head.pc    : '0;
   assign bus.misalign_fault = fault_q;
   assign bus.state          = state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus a randomized
// run, all checked against a queue-based model of the fetch behaviour.
module tb_if_fetch_ctrl;
   import if_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   if_fetch_ctrl_if bus ();

   if_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // clock
   always #5 clk = ~clk;

   // combinational instruction memory: word content derived from its address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F0F};
   endfunction

   assign bus.imem_data = mem_word(bus.imem_addr);

   // ---------------- reference model ----------------
   fetch_entry_t exp_q[$];
   logic [31:0]  m_pc;
   bit           m_fault;

   function automatic bit exp_valid();
      return (exp_q.size() > 0) && !m_fault;
   endfunction

   function automatic bit exp_en();
      return !m_fault && (exp_q.size() < DEPTH);
   endfunction

   function automatic fetch_state_t exp_state();
      if (m_fault)                 return FAULT;
      if (exp_q.size() == DEPTH)   return FULL;
      return FETCH;
   endfunction

   function automatic logic [31:0] exp_instr();
      return exp_valid() ? exp_q[0].instr : NOP_INSTR;
   endfunction

   function automatic logic [31:0] exp_pc();
      return exp_valid() ? exp_q[0].pc : 32'h0;
   endfunction

   // ---------------- driver tasks ----------------
   // Apply inputs (called just after a rising edge) and wait for settled outputs.
   task automatic drive(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit mr, input bit ir);
      reset           = r;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      bus.imem_ready  = mr;
      bus.instr_ready = ir;
      @(negedge clk);
   endtask

   // Clock edge: advance the model with the inputs in force for this cycle.
   task automatic advance();
      bit           pop_m;
      bit           push_m;
      fetch_entry_t e;
      @(posedge clk);
      if (reset) begin
         exp_q.delete();
         m_pc    = RESET_PC;
         m_fault = 1'b0;
      end else begin
         pop_m  = exp_valid() && bus.instr_ready;
         push_m = exp_en() && bus.imem_ready && !bus.redirect;
         if (bus.redirect) begin
            exp_q.delete();
            m_pc    = bus.redirect_pc;
            m_fault = |bus.redirect_pc[1:0];
         end else begin
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) begin
               e.pc    = m_pc;
               e.instr = mem_word(m_pc);
               exp_q.push_back(e);
               m_pc = m_pc + 32'd4;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 32'h0, 1, 1); advance();
      drive(1, 0, 32'h0, 1, 1); advance();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 32'h0, 1, 1);
         checks++;
         if (bus.imem_en !== 1'b0) begin
            failures++; $display("FAIL reset_imem_en actual=%0b expected=0", bus.imem_en);
         end
         advance();
      end
      drive(0, 0, 32'h0, 1, 1);
      checks++;
      if (bus.imem_addr !== RESET_PC || bus.imem_en !== 1'b1) begin
         failures++; $display("FAIL reset_fetch addr=%h en=%0b expected addr=%h en=1",
                              bus.imem_addr, bus.imem_en, RESET_PC);
      end
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.instr !== NOP_INSTR || bus.instr_pc !== 32'h0) begin
         failures++; $display("FAIL reset_outputs valid=%0b instr=%h pc=%h expected 0/%h/0",
                              bus.instr_valid, bus.instr, bus.instr_pc, NOP_INSTR);
      end
      checks++;
      if (bus.misalign_fault !== 1'b0 || bus.state !== FETCH) begin
         failures++; $display("FAIL reset_state fault=%0b state=%0d expected 0/%0d",
                              bus.misalign_fault, bus.state, FETCH);
      end
      advance();
   endtask

   task automatic test_stream();
      logic [31:0] want;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         drive(0, 0, 32'h0, 1, 1);
         checks++;
         if (bus.imem_addr !== 32'(4*k)) begin
            failures++; $display("FAIL stream_addr k=%0d actual=%h expected=%h", k, bus.imem_addr, 32'(4*k));
         end
         checks++;
         if (bus.instr_valid !== (k >= 1)) begin
            failures++; $display("FAIL stream_valid k=%0d actual=%0b expected=%0b", k, bus.instr_valid, (k >= 1));
         end
         if (k >= 1) begin
            want = 32'(4*(k-1));
            checks++;
            if (bus.instr_pc !== want || bus.instr !== mem_word(want)) begin
               failures++; $display("FAIL stream_instr k=%0d pc=%h instr=%h expected %h/%h",
                                    k, bus.instr_pc, bus.instr, want, mem_word(want));
            end
         end
         advance();
      end
   endtask

   task automatic test_full();
      int pushes = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 32'h0, 1, 0);
         if (bus.imem_en && bus.imem_ready) pushes++;
         advance();
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 32'h0, 1, 1);
         if (i == 0) begin
            checks++;
            if (pushes != DEPTH) begin
               failures++; $display("FAIL full_pushes actual=%0d expected=%0d", pushes, DEPTH);
            end
            checks++;
            if (bus.state !== FULL || bus.imem_en !== 1'b0 || bus.imem_addr !== 32'h10) begin
               failures++; $display("FAIL full_state state=%0d en=%0b addr=%h expected %0d/0/00000010",
                                    bus.state, bus.imem_en, bus.imem_addr, FULL);
            end
         end
         checks++;
         if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4*i)) begin
            failures++; $display("FAIL full_drain i=%0d valid=%0b pc=%h expected 1/%h",
                                 i, bus.instr_valid, bus.instr_pc, 32'(4*i));
         end
         advance();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 32'h0, 1, 0); advance();
      end
      drive(0, 1, 32'hB4, 1, 1);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
         failures++; $display("FAIL redir_pre valid=%0b pc=%h expected 1/0", bus.instr_valid, bus.instr_pc);
      end
      advance();
      drive(0, 0, 32'h0, 1, 1);
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'hB4) begin
         failures++; $display("FAIL redir_flush valid=%0b addr=%h expected 0/000000b4",
                              bus.instr_valid, bus.imem_addr);
      end
      advance();
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 32'h0, 1, 1);
         checks++;
         if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(32'hB4 + 4*i)) begin
            failures++; $display("FAIL redir_stream i=%0d valid=%0b pc=%h expected 1/%h",
                                 i, bus.instr_valid, bus.instr_pc, 32'(32'hB4 + 4*i));
         end
         advance();
      end
   endtask

   task automatic test_imem_stall();
      int seen = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 32'h0, 1, 1); advance();
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 32'h0, 0, 1);
         checks++;
         if (bus.imem_addr !== 32'h20 || bus.imem_en !== 1'b1) begin
            failures++; $display("FAIL stall_hold i=%0d addr=%h en=%0b expected 00000020/1",
                                 i, bus.imem_addr, bus.imem_en);
         end
         advance();
      end
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 32'h0, 1, 1);
         if (bus.instr_valid && bus.instr_pc == 32'h20) seen++;
         advance();
      end
      checks++;
      if (seen != 1) begin
         failures++; $display("FAIL stall_once actual=%0d expected=1", seen);
      end
   endtask

   task automatic test_fault();
      drive(0, 1, 32'h102, 1, 1); advance();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 32'h0, 1, 1);
         checks++;
         if (bus.misalign_fault !== 1'b1 || bus.imem_en !== 1'b0 ||
             bus.instr_valid !== 1'b0 || bus.state !== FAULT) begin
            failures++; $display("FAIL fault_hold i=%0d fault=%0b en=%0b valid=%0b state=%0d expected 1/0/0/%0d",
                                 i, bus.misalign_fault, bus.imem_en, bus.instr_valid, bus.state, FAULT);
         end
         advance();
      end
      drive(0, 1, 32'h100, 1, 1); advance();
      drive(0, 0, 32'h0, 1, 1);
      checks++;
      if (bus.misalign_fault !== 1'b0 || bus.imem_addr !== 32'h100 || bus.imem_en !== 1'b1) begin
         failures++; $display("FAIL fault_clear fault=%0b addr=%h en=%0b expected 0/00000100/1",
                              bus.misalign_fault, bus.imem_addr, bus.imem_en);
      end
      advance();
      drive(0, 0, 32'h0, 1, 1);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr !== mem_word(32'h100)) begin
         failures++; $display("FAIL fault_resume valid=%0b pc=%h instr=%h expected 1/00000100/%h",
                              bus.instr_valid, bus.instr_pc, bus.instr, mem_word(32'h100));
      end
      advance();
   endtask

   task automatic test_corner();
      drive(1, 1, 32'h40, 1, 1); advance();
      drive(0, 0, 32'h0, 1, 1);
      checks++;
      if (bus.imem_addr !== RESET_PC) begin
         failures++; $display("FAIL reset_beats_redirect actual=%h expected=%h", bus.imem_addr, RESET_PC);
      end
      advance();
      drive(0, 1, 32'hFFFF_FFFC, 1, 1); advance();
      drive(0, 0, 32'h0, 1, 1);
      checks++;
      if (bus.imem_addr !== 32'hFFFF_FFFC) begin
         failures++; $display("FAIL wrap_start actual=%h expected=fffffffc", bus.imem_addr);
      end
      advance();
      drive(0, 0, 32'h0, 1, 1);
      checks++;
      if (bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC) begin
         failures++; $display("FAIL wrap_next addr=%h valid=%0b pc=%h expected 00000000/1/fffffffc",
                              bus.imem_addr, bus.instr_valid, bus.instr_pc);
      end
      advance();
   endtask

   task automatic test_random();
      bit          r, rd, mr, ir;
      logic [31:0] rpc;
      int          sel;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(63) == 0);
         rd  = ($urandom_range(15) == 0);
         mr  = ($urandom_range(3) != 0);
         ir  = ($urandom_range(2) != 0);
         sel = $urandom_range(7);
         rpc = $urandom & 32'h0000_0FFC;
         if (sel == 0) rpc[1:0] = 2'($urandom_range(3, 1));
         if (sel == 1) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
         drive(r, rd, rpc, mr, ir);
         checks++;
         if (bus.imem_en !== (exp_en() && !r)) begin
            failures++; $display("FAIL rand_en cyc=%0d actual=%0b expected=%0b", i, bus.imem_en, exp_en() && !r);
         end
         checks++;
         if (bus.imem_addr !== m_pc) begin
            failures++; $display("FAIL rand_addr cyc=%0d actual=%h expected=%h", i, bus.imem_addr, m_pc);
         end
         checks++;
         if (bus.instr_valid !== exp_valid()) begin
            failures++; $display("FAIL rand_valid cyc=%0d actual=%0b expected=%0b", i, bus.instr_valid, exp_valid());
         end
         checks++;
         if (bus.instr !== exp_instr() || bus.instr_pc !== exp_pc()) begin
            failures++; $display("FAIL rand_head cyc=%0d instr=%h pc=%h expected %h/%h",
                                 i, bus.instr, bus.instr_pc, exp_instr(), exp_pc());
         end
         checks++;
         if (bus.misalign_fault !== m_fault || bus.state !== exp_state()) begin
            failures++; $display("FAIL rand_state cyc=%0d fault=%0b state=%0d expected %0b/%0d",
                                 i, bus.misalign_fault, bus.state, m_fault, exp_state());
         end
         advance();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      m_pc    = RESET_PC;
      m_fault = 1'b0;
      test_reset();
      test_stream();
      test_full();
      test_redirect();
      test_imem_stall();
      test_fault();
      test_corner();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
